// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_t     - sequencing states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand/sum width
//   cnt_width() - bit counter width for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/fulladder_cmos.sv
// fulladder_cmos: one-bit full-adder cell.
//   a, b, cin - addend bits and carry-in
//   sum, cout - sum bit and carry-out
module fulladder_cmos (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per clock, LSB first, built around a
// single fulladder_cmos cell and a carry flip-flop.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   start_valid/start_ready  - operand handshake (ready only in IDLE)
//   op_a, op_b, cin          - operands and initial carry, sampled at acceptance
//   sub                      - subtract request (only with SERIAL_ADDER_SUB_EN)
//   res_valid/res_ready      - result handshake (valid only in DONE)
//   sum, cout                - registered result
//   busy                     - high in RUN or DONE
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub port (A - B).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_load_b;
  logic             w_load_c;
  logic             w_fa_sum;
  logic             w_fa_cout;

  fulladder_cmos u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  assign w_accept = (r_state == IDLE) && start_valid;
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));

  // Subtraction is A + ~B + 1, so the cell itself never changes.
  always_comb begin
    w_load_b = op_b;
    w_load_c = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      w_load_b = ~op_b;
      w_load_c = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    start_ready  = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= w_load_b;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= w_load_c;
      r_cout  <= 1'b0;
    end else if (r_state == RUN) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
      r_cnt   <= r_cnt + CW'(1);
      r_carry <= w_fa_cout;
      if (w_last) r_cout <= w_fa_cout;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8)
// plus an exhaustive sweep of a WIDTH=2 instance.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start_valid;
  logic       start_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif
  logic       res_valid;
  logic       res_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  logic       start_valid2;
  logic       start_ready2;
  logic [1:0] op_a2;
  logic [1:0] op_b2;
  logic       cin2;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub2;
`endif
  logic       res_valid2;
  logic       res_ready2;
  logic [1:0] sum2;
  logic       cout2;
  logic       busy2;

  int unsigned n_checks;
  int unsigned n_fail;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub         (sub),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid2),
    .start_ready (start_ready2),
    .op_a        (op_a2),
    .op_b        (op_b2),
    .cin         (cin2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub         (sub2),
`endif
    .res_valid   (res_valid2),
    .res_ready   (res_ready2),
    .sum         (sum2),
    .cout        (cout2),
    .busy        (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full WIDTH=8 transaction with res_ready held high.
  task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic s,
                         input logic [7:0] exp_sum, input logic exp_cout);
    int unsigned lat;
    check_eq({tag, ".start_ready"}, 32'(start_ready), 32'd1);
    op_a        = a;
    op_b        = b;
    cin         = c;
`ifdef SERIAL_ADDER_SUB_EN
    sub         = s;
`else
    if (s) $display("note: sub ignored in add-only build");
`endif
    res_ready   = 1'b1;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    // Operands must already be captured.
    op_a = ~a;
    op_b = ~b;
    cin  = ~c;
    check_eq({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, ".latency"}, lat, 32'd8);
    check_eq({tag, ".sum"}, 32'(sum), 32'(exp_sum));
    check_eq({tag, ".cout"}, 32'(cout), 32'(exp_cout));
    tick();
    check_eq({tag, ".back_idle"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    int unsigned lat;
    logic [2:0]  exp3;
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    start_valid  = 1'b0;
    op_a         = '0;
    op_b         = '0;
    cin          = 1'b0;
    res_ready    = 1'b1;
    start_valid2 = 1'b0;
    op_a2        = '0;
    op_b2        = '0;
    cin2         = 1'b0;
    res_ready2   = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub          = 1'b0;
    sub2         = 1'b0;
`endif

    #12;
    check_eq("rst.start_ready", 32'(start_ready), 32'd1);
    check_eq("rst.res_valid", 32'(res_valid), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.sum", 32'(sum), 32'd0);
    check_eq("rst.cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op8("add5A3C", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    run_op8("addFF01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op8("addFFFF", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

    // Stall in DONE with res_ready low; start_valid pulses must be ignored.
    res_ready   = 1'b0;
    op_a        = 8'h12;
    op_b        = 8'h34;
    cin         = 1'b1;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("stall.latency", lat, 32'd8);
    for (int i = 0; i < 5; i++) begin
      op_a        = 8'hC3;
      op_b        = 8'h7E;
      start_valid = i[0];
      tick();
      check_eq("stall.res_valid", 32'(res_valid), 32'd1);
      check_eq("stall.sum", 32'(sum), 32'h47);
      check_eq("stall.cout", 32'(cout), 32'd0);
      check_eq("stall.start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    tick();
    check_eq("release.start_ready", 32'(start_ready), 32'd1);
    check_eq("release.res_valid", 32'(res_valid), 32'd0);
    check_eq("release.sum_held", 32'(sum), 32'h47);

    // Reset three cycles into RUN.
    op_a        = 8'hAA;
    op_b        = 8'h55;
    cin         = 1'b1;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("abort.start_ready", 32'(start_ready), 32'd1);
    check_eq("abort.res_valid", 32'(res_valid), 32'd0);
    check_eq("abort.busy", 32'(busy), 32'd0);
    check_eq("abort.sum", 32'(sum), 32'd0);
    check_eq("abort.cout", 32'(cout), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    run_op8("add0102", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op8("sub1001", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op8("sub0102", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
    sub = 1'b0;
`endif

    // Exhaustive sweep on the WIDTH=2 instance.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          op_a2        = 2'(a);
          op_b2        = 2'(b);
          cin2         = 1'(c);
          start_valid2 = 1'b1;
          tick();
          start_valid2 = 1'b0;
          lat = 0;
          while (!res_valid2 && lat < 10) begin
            tick();
            lat++;
          end
          exp3 = 3'(a + b + c);
          if (lat != 2) check_eq("w2.latency", lat, 32'd2);
          check_eq($sformatf("w2.%0d+%0d+%0d", a, b, c), 32'({cout2, sum2}), 32'(exp3));
          tick();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
